// File: rtl/seq_mult6_ctrl_if.sv
// rtl/seq_mult6_ctrl_if.sv - operand/result bundle for the sequential 6x6 multiplier
//
// Signals:
//   start    request; sampled by the multiplier only while idle
//   a, b     6-bit unsigned multiplicand / multiplier, sampled with start
//   busy     high while an operation (add or done phase) is in flight
//   done     one-cycle pulse; product is valid in that cycle
//   product  12-bit result register, holds between operations
// master: requester side; slave: multiplier side.
interface seq_mult6_ctrl_if;
  logic        start;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] product;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input product);
  modport slave  (input  start, input  a,  input  b,
                  output busy,  output done, output product);
endinterface

// File: rtl/twelveBitFullAdder.sv
// rtl/twelveBitFullAdder.sv - 12-bit ripple-carry adder
//
// Ports:
//   A, B  12-bit addends
//   Cin   carry in
//   Sum   12-bit sum
//   Cout  carry out of bit 11
module twelveBitFullAdder (
  input  logic [11:0] A,
  input  logic [11:0] B,
  input  logic        Cin,
  output logic [11:0] Sum,
  output logic        Cout
);
  logic carry;

  // Carry is rippled through a single variable so the chain stays a plain
  // sequence of full-adder cells.
  always_comb begin
    Sum   = '0;
    carry = Cin;
    for (int i = 0; i < 12; i++) begin
      Sum[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end
endmodule

// File: rtl/seq_mult6_ctrl.sv
// rtl/seq_mult6_ctrl.sv - sequential 6x6 unsigned shift-and-add multiplier controller
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     seq_mult6_ctrl_if.slave: start/a/b in, busy/done/product out
// Parameter:
//   EARLY_EXIT  0: always 6 add cycles; 1: finish once remaining multiplier bits are zero
module seq_mult6_ctrl #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_mult6_ctrl_if.slave     bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ADD, ST_DONE} state_t;

  state_t      state_q,   state_d;
  logic [11:0] mcand_q,   mcand_d;
  logic [5:0]  mplier_q,  mplier_d;
  logic [11:0] acc_q,     acc_d;
  logic [2:0]  cnt_q,     cnt_d;
  logic [11:0] product_q, product_d;

  logic [11:0] addend;
  logic [11:0] sum;
  logic        adder_cout_unused;

  // Partial product for this step: multiplicand gated by the current multiplier LSB.
  assign addend = mcand_q & {12{mplier_q[0]}};

  // 63*63 fits in 12 bits, so the carry out never matters.
  twelveBitFullAdder u_adder (
    .A    (acc_q),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (adder_cout_unused)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = {6'b0, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        acc_d    = sum;
        mcand_d  = {mcand_q[10:0], 1'b0};
        mplier_d = {1'b0, mplier_q[5:1]};
        cnt_d    = cnt_q + 3'd1;
        // Product is captured on the way into DONE so it is already valid
        // while done is high.
        if (cnt_q == 3'd5 || (EARLY_EXIT && mplier_d == 6'd0)) begin
          product_d = sum;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Moore outputs: decoded from state only.
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult6_ctrl.sv
// tb/tb_seq_mult6_ctrl.sv - scoreboard bench for seq_mult6_ctrl (EARLY_EXIT 0 and 1)
module tb_seq_mult6_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mult6_ctrl_if if0 ();
  seq_mult6_ctrl_if if1 ();

  seq_mult6_ctrl #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seq_mult6_ctrl #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int prod;
    int when;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference timing: full 6 steps, or with early exit the bit length of b
  // (at least 1 step), plus the done cycle.
  function automatic int ref_lat(input bit ee, input int bv);
    int k;
    if (!ee) return 7;
    k = 0;
    while ((bv >> k) != 0) k++;
    if (k < 1) k = 1;
    return k + 1;
  endfunction

  task automatic set_in(input int u, input logic s, input logic [5:0] av, input logic [5:0] bv);
    if (u == 0) begin
      if0.start = s; if0.a = av; if0.b = bv;
    end else begin
      if1.start = s; if1.a = av; if1.b = bv;
    end
  endtask

  task automatic get_out(input int u, output logic bsy, output logic dn, output logic [11:0] pr);
    if (u == 0) begin
      bsy = if0.busy; dn = if0.done; pr = if0.product;
    end else begin
      bsy = if1.busy; dn = if1.done; pr = if1.product;
    end
  endtask

  // Issue one operation from an idle DUT; returns in the first idle cycle after it.
  // hold keeps start high throughout; poke raises start with 9,9 during the add phase.
  task automatic do_op(input int u, input logic [5:0] av, input logic [5:0] bv,
                       input bit hold, input bit poke);
    int   lat;
    int   expp;
    exp_t e;
    logic bsy, dn;
    logic [11:0] pr;
    lat  = ref_lat(u == 1, int'(bv));
    expp = int'(av) * int'(bv);
    set_in(u, 1'b1, av, bv);
    @(posedge clk); #1;
    e.prod = expp;
    e.when = cyc + lat - 1;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    set_in(u, hold, 6'($urandom), 6'($urandom));
    get_out(u, bsy, dn, pr);
    check("busy_after_start", {31'b0, bsy}, 1);
    if (poke) begin
      @(posedge clk); #1;
      set_in(u, 1'b1, 6'd9, 6'd9);
      @(posedge clk); #1;
      set_in(u, hold, 6'($urandom), 6'($urandom));
      repeat (lat - 2) begin @(posedge clk); #1; end
    end else begin
      repeat (lat) begin @(posedge clk); #1; end
    end
    get_out(u, bsy, dn, pr);
    check("busy_idle", {31'b0, bsy}, 0);
    check("done_idle", {31'b0, dn}, 0);
    check("product_hold", {20'b0, pr}, expp);
  endtask

  task automatic mon_pop(input int u);
    exp_t e;
    logic bsy, dn;
    logic [11:0] pr;
    get_out(u, bsy, dn, pr);
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_unexpected: dut%0d pulsed done with product %0d, expected no pulse (cycle %0d)", u, pr, cyc);
    end else begin
      if (u == 0) e = q0.pop_front(); else e = q1.pop_front();
      check(u == 0 ? "product0" : "product1", {20'b0, pr}, e.prod);
      check(u == 0 ? "done_cycle0" : "done_cycle1", cyc, e.when);
      check(u == 0 ? "busy_in_done0" : "busy_in_done1", {31'b0, bsy}, 1);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (if0.done) mon_pop(0);
      if (if1.done) mon_pop(1);
    end
  end

  task automatic sweep(input int u);
    for (int av = 0; av < 64; av++)
      for (int bv = 0; bv < 64; bv++)
        do_op(u, 6'(av), 6'(bv), ($urandom % 4) == 0, 1'b0);
    set_in(u, 1'b0, 6'd0, 6'd0);
  endtask

  task automatic rand_ops(input int u);
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      do_op(u, 6'($urandom), 6'($urandom), 1'b0, (u == 0) && (($urandom % 3) == 0));
    end
  endtask

  task automatic reset_mid_op();
    logic bsy, dn;
    logic [11:0] pr;
    set_in(0, 1'b1, 6'd63, 6'd63);
    @(posedge clk); #1;
    set_in(0, 1'b0, 6'd0, 6'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    get_out(0, bsy, dn, pr);
    check("rst_busy0", {31'b0, bsy}, 0);
    check("rst_done0", {31'b0, dn}, 0);
    check("rst_product0", {20'b0, pr}, 0);
    get_out(1, bsy, dn, pr);
    check("rst_product1", {20'b0, pr}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic bsy, dn;
    logic [11:0] pr;
    set_in(0, 1'b0, 6'd0, 6'd0);
    set_in(1, 1'b0, 6'd0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      get_out(u, bsy, dn, pr);
      check("reset_busy", {31'b0, bsy}, 0);
      check("reset_done", {31'b0, dn}, 0);
      check("reset_product", {20'b0, pr}, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(0, 6'd5, 6'd7, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("product_35_later", {20'b0, if0.product}, 35);
    do_op(0, 6'd63, 6'd63, 1'b0, 1'b0);
    do_op(0, 6'd0, 6'd45, 1'b0, 1'b0);
    do_op(0, 6'd2, 6'd3, 1'b0, 1'b1);
    do_op(0, 6'd9, 6'd9, 1'b0, 1'b0);
    do_op(0, 6'd1, 6'd2, 1'b1, 1'b0);
    do_op(0, 6'd3, 6'd4, 1'b1, 1'b0);
    do_op(0, 6'd7, 6'd11, 1'b0, 1'b0);

    do_op(1, 6'd45, 6'd0, 1'b0, 1'b0);
    do_op(1, 6'd10, 6'd3, 1'b0, 1'b0);
    do_op(1, 6'd10, 6'd32, 1'b0, 1'b0);
    do_op(1, 6'd63, 6'd63, 1'b0, 1'b0);

    reset_mid_op();
    do_op(0, 6'd4, 6'd4, 1'b0, 1'b0);

    fork
      sweep(0);
      sweep(1);
    join
    fork
      rand_ops(0);
      rand_ops(1);
    join

    repeat (10) begin @(posedge clk); #1; end
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
